// File: rtl/cmem_arb.sv
// cmem_arb: round-robin arbiter that funnels line-fill and writeback requests
// from N_PORTS cache ports onto one upstream line port, and broadcasts line
// invalidates after writebacks and on external invalidate strobes.
module cmem_arb #(
  parameter int N_PORTS = 2,
  parameter int LINE    = 256,
  parameter int ADDR_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS*ADDR_W-1:0] b_addr,
  input  logic [N_PORTS-1:0]        b_rd,
  input  logic [N_PORTS-1:0]        b_wr,
  input  logic [N_PORTS*LINE-1:0]   b_data_out,
  output logic [LINE-1:0]           b_data_in,
  output logic [N_PORTS-1:0]        b_dv,
  output logic [N_PORTS-1:0]        b_inv,
  output logic [ADDR_W-1:0]         b_inv_addr,
  output logic [ADDR_W-1:0]         h_addr,
  output logic                      h_rd,
  output logic                      h_wr,
  output logic [LINE-1:0]           h_data_out,
  input  logic [LINE-1:0]           h_data_in,
  input  logic                      h_dv,
  input  logic                      inv,
  input  logic [ADDR_W-1:0]         inv_addr
);

  localparam int OFF_W = $clog2(LINE / 8);
  localparam int IDX_W = $clog2(N_PORTS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_INV  = 3'd4
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    grant_q;
  logic                wr_q;
  logic                inv_pend_q;
  logic [N_PORTS-1:0]  b_dv_q;
  logic [N_PORTS-1:0]  b_inv_q;
  logic [ADDR_W-1:0]   b_inv_addr_q;
  logic [LINE-1:0]     b_data_in_q;
  logic [ADDR_W-1:0]   h_addr_q;
  logic                h_rd_q;
  logic                h_wr_q;
  logic [LINE-1:0]     h_data_out_q;

  logic [N_PORTS-1:0]  req_s;
  logic                gnt_vld_d;
  logic [IDX_W-1:0]    gnt_idx_d;
  logic                int_inv_s;

  // Clear the byte-offset bits so the address names a whole line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  function automatic logic [N_PORTS-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return {{(N_PORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign req_s = b_rd | b_wr;

  // The writeback invalidate goes out on leaving DONE, or later if an external one took its slot.
  assign int_inv_s = ((state_q == S_DONE) && wr_q) || ((state_q == S_INV) && inv_pend_q);

  // Round-robin search: first requester at or after rr_ptr+1, wrapping.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_idx_d = {IDX_W{1'b0}};
    for (int i = 1; i <= N_PORTS; i++) begin
      logic [IDX_W-1:0] cand;
      logic             hit;
      cand      = IDX_W'((int'(rr_ptr_q) + i) % N_PORTS);
      hit       = req_s[cand] && !gnt_vld_d;
      gnt_idx_d = hit ? cand : gnt_idx_d;
      gnt_vld_d = gnt_vld_d | hit;
    end
  end

  // Transaction FSM; every output is a register so nothing combinational leaves the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDX_W'(N_PORTS - 1);
      grant_q      <= {IDX_W{1'b0}};
      wr_q         <= 1'b0;
      inv_pend_q   <= 1'b0;
      b_dv_q       <= {N_PORTS{1'b0}};
      b_inv_q      <= {N_PORTS{1'b0}};
      b_inv_addr_q <= {ADDR_W{1'b0}};
      b_data_in_q  <= {LINE{1'b0}};
      h_addr_q     <= {ADDR_W{1'b0}};
      h_rd_q       <= 1'b0;
      h_wr_q       <= 1'b0;
      h_data_out_q <= {LINE{1'b0}};
    end else begin
      b_dv_q <= {N_PORTS{1'b0}};

      // External invalidates always win the b_inv slot; the writeback one waits.
      if (inv) begin
        b_inv_q      <= {N_PORTS{1'b1}};
        b_inv_addr_q <= line_align(inv_addr);
      end else if (int_inv_s) begin
        b_inv_q      <= ~one_hot(grant_q);
        b_inv_addr_q <= h_addr_q;
      end else begin
        b_inv_q      <= {N_PORTS{1'b0}};
      end

      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            grant_q      <= gnt_idx_d;
            h_addr_q     <= line_align(b_addr[int'(gnt_idx_d)*ADDR_W +: ADDR_W]);
            h_data_out_q <= b_data_out[int'(gnt_idx_d)*LINE +: LINE];
            wr_q         <= b_wr[gnt_idx_d];
            // A writeback outranks a simultaneous fill on the same port.
            if (b_wr[gnt_idx_d]) begin
              h_wr_q  <= 1'b1;
              state_q <= S_WR;
            end else begin
              h_rd_q  <= 1'b1;
              state_q <= S_RD;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD: begin
          if (h_dv) begin
            b_data_in_q <= h_data_in;
            h_rd_q      <= 1'b0;
            b_dv_q      <= one_hot(grant_q);
            state_q     <= S_DONE;
          end else begin
            state_q     <= S_RD;
          end
        end
        S_WR: begin
          if (h_dv) begin
            h_wr_q  <= 1'b0;
            b_dv_q  <= one_hot(grant_q);
            state_q <= S_DONE;
          end else begin
            state_q <= S_WR;
          end
        end
        S_DONE: begin
          rr_ptr_q   <= grant_q;
          inv_pend_q <= wr_q & inv;
          state_q    <= wr_q ? S_INV : S_IDLE;
        end
        S_INV: begin
          if (!inv_pend_q) begin
            state_q <= S_IDLE;
          end else if (!inv) begin
            inv_pend_q <= 1'b0;
            state_q    <= S_INV;
          end else begin
            state_q    <= S_INV;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign b_dv       = b_dv_q;
  assign b_inv      = b_inv_q;
  assign b_inv_addr = b_inv_addr_q;
  assign b_data_in  = b_data_in_q;
  assign h_addr     = h_addr_q;
  assign h_rd       = h_rd_q;
  assign h_wr       = h_wr_q;
  assign h_data_out = h_data_out_q;

endmodule

// File: tb/tb_cmem_arb.sv
// tb_cmem_arb: directed vector table, hand sequences for multi-cycle corners,
// then random traffic checked against a transaction-level model.
module tb_cmem_arb;

  localparam int N    = 2;
  localparam int LINE = 256;
  localparam int AW   = 64;
  localparam logic [AW-1:0] AMASK = ~64'h1F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*AW-1:0]   b_addr = '0;
  logic [N-1:0]      b_rd = '0;
  logic [N-1:0]      b_wr = '0;
  logic [N*LINE-1:0] b_data_out = '0;
  logic [LINE-1:0]   b_data_in;
  logic [N-1:0]      b_dv;
  logic [N-1:0]      b_inv;
  logic [AW-1:0]     b_inv_addr;
  logic [AW-1:0]     h_addr;
  logic              h_rd;
  logic              h_wr;
  logic [LINE-1:0]   h_data_out;
  logic [LINE-1:0]   h_data_in = '0;
  logic              h_dv = 1'b0;
  logic              inv = 1'b0;
  logic [AW-1:0]     inv_addr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmem_arb #(.N_PORTS(N), .LINE(LINE), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr),
    .b_data_out(b_data_out), .b_data_in(b_data_in), .b_dv(b_dv), .b_inv(b_inv),
    .b_inv_addr(b_inv_addr), .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr),
    .h_data_out(h_data_out), .h_data_in(h_data_in), .h_dv(h_dv), .inv(inv),
    .inv_addr(inv_addr)
  );

  typedef struct {
    int            port;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_haddr;
    bit            exp_wr;
    logic [N-1:0]  exp_inv;
  } vec_t;

  task automatic chk(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE-1:0] rand_line();
    logic [LINE-1:0] v;
    for (int i = 0; i < LINE/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  // First requester strictly after 'lst', wrapping around.
  function automatic int pick(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++) if (r[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  task automatic wait_hreq(output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      seen = h_rd || h_wr;
    end
    if (!seen) chk("wait_hreq_timeout", waited, 0);
  endtask

  task automatic run_txn(input vec_t v);
    logic [LINE-1:0] wd, rd;
    bit seen;
    int waited;
    wd = rand_line();
    b_addr[v.port*AW +: AW] = v.addr;
    b_data_out[v.port*LINE +: LINE] = wd;
    b_rd[v.port] = v.rd;
    b_wr[v.port] = v.wr;
    wait_hreq(seen, waited);
    if (!seen) begin
      b_rd = '0; b_wr = '0;
      return;
    end
    chk("txn_grant_latency", waited, 1);
    chk("txn_h_wr", h_wr, v.exp_wr);
    chk("txn_h_rd", h_rd, !v.exp_wr);
    chk("txn_h_addr", h_addr, v.exp_haddr);
    if (v.exp_wr) chk("txn_h_data_out", h_data_out, wd);
    chk("txn_b_dv_early", b_dv, 0);
    rd = rand_line();
    h_data_in = rd;
    h_dv = 1'b1;
    @(negedge clk);
    h_dv = 1'b0;
    b_rd[v.port] = 1'b0;
    b_wr[v.port] = 1'b0;
    chk("txn_b_dv", b_dv, onehot(v.port));
    chk("txn_h_req_drop", {h_rd, h_wr}, 2'b00);
    if (!v.exp_wr) chk("txn_b_data_in", b_data_in, rd);
    @(negedge clk);
    chk("txn_b_dv_pulse", b_dv, 0);
    chk("txn_b_inv", b_inv, v.exp_inv);
    if (v.exp_inv != '0) chk("txn_b_inv_addr", b_inv_addr, v.exp_haddr);
    @(negedge clk);
    chk("txn_b_inv_pulse", b_inv, 0);
  endtask

  task automatic contention();
    bit seen;
    int waited, ep;
    b_addr[0 +: AW] = 64'h100;
    b_addr[AW +: AW] = 64'h200;
    b_rd = 2'b11;
    for (int t = 0; t < 4; t++) begin
      ep = t % 2;
      wait_hreq(seen, waited);
      if (!seen) break;
      chk("cont_h_addr", h_addr, (ep == 1) ? 64'h200 : 64'h100);
      h_data_in = rand_line();
      h_dv = 1'b1;
      @(negedge clk);
      h_dv = 1'b0;
      chk("cont_b_dv", b_dv, onehot(ep));
    end
    b_rd = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic collision();
    logic [LINE-1:0] wd;
    bit seen;
    int waited;
    wd = rand_line();
    b_addr[AW +: AW] = 64'h40;
    b_data_out[LINE +: LINE] = wd;
    b_wr = 2'b10;
    wait_hreq(seen, waited);
    if (!seen) begin
      b_wr = '0;
      return;
    end
    chk("col_h_wr", h_wr, 1);
    chk("col_h_data_out", h_data_out, wd);
    h_dv = 1'b1;
    @(negedge clk);
    h_dv = 1'b0;
    b_wr = '0;
    chk("col_b_dv", b_dv, 2'b10);
    inv = 1'b1;
    inv_addr = 64'h8F;
    @(negedge clk);
    inv = 1'b0;
    chk("col_ext_inv", b_inv, 2'b11);
    chk("col_ext_inv_addr", b_inv_addr, 64'h80);
    @(negedge clk);
    chk("col_wb_inv", b_inv, 2'b01);
    chk("col_wb_inv_addr", b_inv_addr, 64'h40);
    @(negedge clk);
    chk("col_inv_end", b_inv, 2'b00);
  endtask

  task automatic ext_inv_idle();
    inv = 1'b1;
    inv_addr = 64'h1234_5678;
    @(negedge clk);
    inv = 1'b0;
    chk("ext_inv_all", b_inv, 2'b11);
    chk("ext_inv_addr", b_inv_addr, 64'h1234_5660);
    @(negedge clk);
    chk("ext_inv_pulse", b_inv, 2'b00);
  endtask

  task automatic reset_abort();
    bit seen;
    int waited;
    b_addr[0 +: AW] = 64'h5000;
    b_rd = 2'b01;
    wait_hreq(seen, waited);
    #1 rst = 1'b1;
    #1;
    chk("rst_h_rd_async", h_rd, 0);
    chk("rst_b_dv_async", b_dv, 0);
    chk("rst_h_addr", h_addr, 0);
    b_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    h_data_in = rand_line();
    h_dv = 1'b1;
    @(negedge clk);
    h_dv = 1'b0;
    chk("late_h_dv_b_dv", b_dv, 0);
    chk("late_h_dv_h_rd", h_rd, 0);
    chk("late_h_dv_b_data_in", b_data_in, 0);
    @(negedge clk);
    chk("late_h_dv_b_dv2", b_dv, 0);
  endtask

  task automatic random_phase();
    logic [N-1:0]    req_act, req_prev, exp_dv, exp_inv, nx_dv, nx_inv;
    logic [AW-1:0]   r_addr [N];
    logic [LINE-1:0] r_data [N];
    bit              r_wr [N];
    logic [AW-1:0]   exp_inv_addr, nx_inv_addr;
    logic [LINE-1:0] exp_bdin;
    int              last, cur, wait_c, idle_cnt, e, n_done;
    int unsigned     k;
    bit              busy, dv_sent, cur_wr;
    req_act = '0; req_prev = '0; exp_dv = '0; exp_inv = '0;
    exp_inv_addr = '0; exp_bdin = '0;
    last = N - 1; cur = 0; wait_c = 0; idle_cnt = 0; n_done = 0;
    busy = 1'b0; dv_sent = 1'b0; cur_wr = 1'b0;
    for (int p = 0; p < N; p++) begin
      r_addr[p] = '0; r_data[p] = '0; r_wr[p] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_b_dv", b_dv, exp_dv);
      chk("rnd_b_inv", b_inv, exp_inv);
      if (exp_inv != '0) chk("rnd_b_inv_addr", b_inv_addr, exp_inv_addr);
      chk("rnd_b_data_in", b_data_in, exp_bdin);
      chk("rnd_h_excl", h_rd & h_wr, 0);
      nx_dv = '0;
      nx_inv = '0;
      nx_inv_addr = exp_inv_addr;
      if (exp_dv != '0) begin
        chk("rnd_h_drop", {h_rd, h_wr}, 2'b00);
        if (cur_wr) begin
          nx_inv = ~exp_dv;
          nx_inv_addr = r_addr[cur] & AMASK;
        end
        req_act[cur] = 1'b0;
        b_rd[cur] = 1'b0;
        b_wr[cur] = 1'b0;
        last = cur;
        busy = 1'b0;
        n_done++;
        idle_cnt = 0;
      end else if (!busy && (h_rd || h_wr)) begin
        e = pick(req_prev, last);
        if (e < 0) begin
          chk("rnd_spurious_req", {h_rd, h_wr}, 2'b00);
        end else begin
          chk("rnd_h_addr", h_addr, r_addr[e] & AMASK);
          chk("rnd_h_wr", h_wr, r_wr[e]);
          if (r_wr[e]) chk("rnd_h_data_out", h_data_out, r_data[e]);
          cur = e;
          cur_wr = r_wr[e];
          busy = 1'b1;
          dv_sent = 1'b0;
          wait_c = $urandom_range(3, 0);
        end
      end
      h_dv = 1'b0;
      if (busy && !dv_sent) begin
        if (wait_c == 0) begin
          h_data_in = rand_line();
          h_dv = 1'b1;
          dv_sent = 1'b1;
          nx_dv = onehot(cur);
          if (!cur_wr) exp_bdin = h_data_in;
        end else begin
          wait_c--;
        end
      end
      for (int p = 0; p < N; p++) begin
        if (!req_act[p] && ($urandom_range(3, 0) == 0)) begin
          k = $urandom_range(9, 0);
          r_addr[p] = {$urandom, $urandom};
          r_data[p] = rand_line();
          r_wr[p] = (k >= 5);
          b_addr[p*AW +: AW] = r_addr[p];
          b_data_out[p*LINE +: LINE] = r_data[p];
          b_rd[p] = (k < 5) || (k == 9);
          b_wr[p] = (k >= 5);
          req_act[p] = 1'b1;
        end
      end
      if (req_act != '0) idle_cnt++;
      if (idle_cnt > 60) begin
        chk("rnd_watchdog", idle_cnt, 0);
        break;
      end
      req_prev = req_act;
      exp_dv = nx_dv;
      exp_inv = nx_inv;
      exp_inv_addr = nx_inv_addr;
    end
    chk("rnd_progress", n_done > 100, 1);
    b_rd = '0;
    b_wr = '0;
    h_dv = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    vecs[0] = '{0, 1'b1, 1'b0, 64'h1234,                64'h1220,                1'b0, 2'b00};
    vecs[1] = '{1, 1'b0, 1'b1, 64'h40,                  64'h40,                  1'b1, 2'b01};
    vecs[2] = '{0, 1'b1, 1'b1, 64'h1F,                  64'h0,                   1'b1, 2'b10};
    vecs[3] = '{1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0, 1'b0, 2'b00};
    vecs[4] = '{0, 1'b0, 1'b1, 64'hABCD_0000_0000_1FFF, 64'hABCD_0000_0000_1FE0, 1'b1, 2'b10};
    vecs[5] = '{1, 1'b1, 1'b1, 64'h20,                  64'h20,                  1'b1, 2'b01};

    repeat (2) @(negedge clk);
    chk("rst_b_dv", b_dv, 0);
    chk("rst_b_inv", b_inv, 0);
    chk("rst_h_rd_wr", {h_rd, h_wr}, 2'b00);
    chk("rst_h_addr", h_addr, 0);
    chk("rst_b_inv_addr", b_inv_addr, 0);
    chk("rst_b_data_in", b_data_in, 0);
    chk("rst_h_data_out", h_data_out, 0);
    rst = 1'b0;
    @(negedge clk);

    contention();
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);
    collision();
    ext_inv_idle();
    reset_abort();
    random_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
